// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// the hard-wired zero register index and counter widths.
package hazard_pkg;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_FLUSH    = 2'd1,
        HZ_MEM_WAIT = 2'd2
    } hz_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int unsigned CNT_W   = 32;  // performance counter width
    localparam int unsigned FCNT_W  = 3;   // flush counter width (FLUSH_CYCLES <= 7)

endpackage

// File: rtl/hazard_load_use_detect.sv
// Load-use comparator: the instruction in EX is a load whose destination
// (other than x0) is read by the instruction currently in ID.
module hazard_load_use_detect
    import hazard_pkg::*;
(
    input  logic       ex_MemRead,
    input  logic [4:0] ex_destination_reg,
    input  logic [4:0] id_source_reg1,
    input  logic [4:0] id_source_reg2,
    output logic       load_use
);

    // Pure compare; x0 never creates a dependency.
    always_comb begin
        load_use = ex_MemRead
                && (ex_destination_reg != REG_ZERO)
                && ((ex_destination_reg == id_source_reg1)
                 || (ex_destination_reg == id_source_reg2));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, taken-branch flush window
// and load-use stall, in that priority order.
// Optional build macro HAZARD_PERF_CNT_EN adds stall/flush cycle counters.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_source_reg1,
    input  logic [4:0]       id_source_reg2,
    input  logic [4:0]       ex_destination_reg,
    input  logic             ex_MemRead,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             pipe_hold,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles,
`endif
    output logic [1:0]       hazard_state
);

    // Remaining flush cycles after the one in which the branch resolves.
    localparam logic [FCNT_W-1:0] FLUSH_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);

    hz_state_e         state_q, state_d;
    logic [FCNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic              load_use;

    logic fsm_pc_write, fsm_if_id_write, fsm_if_id_flush, fsm_id_ex_flush, fsm_pipe_hold;

    hazard_load_use_detect u_lu (
        .ex_MemRead         (ex_MemRead),
        .ex_destination_reg (ex_destination_reg),
        .id_source_reg1     (id_source_reg1),
        .id_source_reg2     (id_source_reg2),
        .load_use           (load_use)
    );

    // State and flush counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= HZ_RUN;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next-state and control outputs; mem_busy dominates, then branch/flush, then load-use.
    always_comb begin
        state_d         = state_q;
        flush_cnt_d     = flush_cnt_q;
        fsm_pc_write    = 1'b1;
        fsm_if_id_write = 1'b1;
        fsm_if_id_flush = 1'b0;
        fsm_id_ex_flush = 1'b0;
        fsm_pipe_hold   = 1'b0;

        if (mem_busy) begin
            // Freeze everything; a pending flush count is kept for later.
            fsm_pc_write    = 1'b0;
            fsm_if_id_write = 1'b0;
            fsm_pipe_hold   = 1'b1;
            state_d         = HZ_MEM_WAIT;
        end else begin
            case (state_q)
                HZ_MEM_WAIT: begin
                    if (branch_taken) begin
                        // A branch resolving on the release cycle must not be lost.
                        fsm_if_id_flush = 1'b1;
                        fsm_id_ex_flush = 1'b1;
                        flush_cnt_d     = FLUSH_RELOAD;
                        state_d         = (FLUSH_RELOAD != '0) ? HZ_FLUSH : HZ_RUN;
                    end else begin
                        // Release cycle: resume any interrupted flush next cycle.
                        // Load-use stays suppressed here.
                        state_d = (flush_cnt_q != '0) ? HZ_FLUSH : HZ_RUN;
                    end
                end
                HZ_FLUSH: begin
                    fsm_if_id_flush = 1'b1;
                    fsm_id_ex_flush = 1'b1;
                    if (branch_taken) begin
                        flush_cnt_d = FLUSH_RELOAD;
                        state_d     = (FLUSH_RELOAD != '0) ? HZ_FLUSH : HZ_RUN;
                    end else begin
                        flush_cnt_d = (flush_cnt_q != '0) ? flush_cnt_q - 1'b1 : '0;
                        state_d     = (flush_cnt_q > 1) ? HZ_FLUSH : HZ_RUN;
                    end
                end
                default: begin
                    // RUN (and any unused encoding, which recovers to RUN).
                    state_d = HZ_RUN;
                    if (branch_taken) begin
                        fsm_if_id_flush = 1'b1;
                        fsm_id_ex_flush = 1'b1;
                        flush_cnt_d     = FLUSH_RELOAD;
                        state_d         = (FLUSH_RELOAD != '0) ? HZ_FLUSH : HZ_RUN;
                    end else if (load_use) begin
                        fsm_pc_write    = 1'b0;
                        fsm_if_id_write = 1'b0;
                        fsm_id_ex_flush = 1'b1;
                    end
                end
            endcase
        end
    end

    // While in reset, hold the front end and keep bubbles flowing.
    always_comb begin
        if (!rst_n) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            pipe_hold    = 1'b0;
            hazard_state = HZ_RUN;
        end else begin
            pc_write     = fsm_pc_write;
            if_id_write  = fsm_if_id_write;
            if_id_flush  = fsm_if_id_flush;
            id_ex_flush  = fsm_id_ex_flush;
            pipe_hold    = fsm_pipe_hold;
            hazard_state = state_q;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cyc_q;

    // Free-running wrap-around counters of stalled and bubble-inserting cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cyc_q <= '0;
        end else begin
            if (!pc_write)   stall_cnt_q <= stall_cnt_q + 1'b1;
            if (id_ex_flush) flush_cyc_q <= flush_cyc_q + 1'b1;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_cycles = flush_cyc_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a per-cycle reference model.
module tb_pipeline_hazard_ctrl;

    localparam int F = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
    logic       mr = 1'b0, br = 1'b0, busy = 1'b0;

    logic       pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold;
    logic [1:0] hazard_state;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_cycles;
`endif

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(F)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .id_source_reg1     (rs1),
        .id_source_reg2     (rs2),
        .ex_destination_reg (rd),
        .ex_MemRead         (mr),
        .branch_taken       (br),
        .mem_busy           (busy),
        .pc_write           (pc_write),
        .if_id_write        (if_id_write),
        .if_id_flush        (if_id_flush),
        .id_ex_flush        (id_ex_flush),
        .pipe_hold          (pipe_hold),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles       (stall_cycles),
        .flush_cycles       (flush_cycles),
`endif
        .hazard_state       (hazard_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owed flush cycles, whether a memory wait is in progress,
    // and running event counts.
    int pend = 0, n_pend = 0;
    bit waiting = 1'b0, n_waiting = 1'b0;
    int m_stall = 0, m_flush = 0, n_stall = 0, n_flush = 0;

    // Compare every cycle against the rule-level model; commit model at posedge.
    always @(negedge clk) begin
        bit e_pcw, e_ifw, e_iff, e_ief, e_hold;
        bit lu;
        int e_st;
        lu = mr && (rd != 0) && (rd == rs1 || rd == rs2);
        e_st = waiting ? 2 : (pend > 0 ? 1 : 0);
        n_pend = pend;
        n_waiting = waiting;
        {e_pcw, e_ifw, e_iff, e_ief, e_hold} = 5'b11000;
        if (!rst_n) begin
            {e_pcw, e_ifw, e_iff, e_ief, e_hold} = 5'b00110;
            e_st = 0;
            n_pend = 0;
            n_waiting = 0;
        end else if (busy) begin
            {e_pcw, e_ifw, e_iff, e_ief, e_hold} = 5'b00001;
            n_waiting = 1;
        end else if (br) begin
            {e_iff, e_ief} = 2'b11;
            n_pend = F - 1;
            n_waiting = 0;
        end else if (waiting) begin
            n_waiting = 0;
        end else if (pend > 0) begin
            {e_iff, e_ief} = 2'b11;
            n_pend = pend - 1;
        end else if (lu) begin
            {e_pcw, e_ifw, e_ief} = 3'b001;
        end
        chk("pc_write", pc_write, e_pcw);
        chk("if_id_write", if_id_write, e_ifw);
        chk("if_id_flush", if_id_flush, e_iff);
        chk("id_ex_flush", id_ex_flush, e_ief);
        chk("pipe_hold", pipe_hold, e_hold);
        chk("hazard_state", hazard_state, e_st);
`ifdef HAZARD_PERF_CNT_EN
        chk("stall_cycles", stall_cycles, m_stall);
        chk("flush_cycles", flush_cycles, m_flush);
`endif
        n_stall = rst_n ? m_stall + (e_pcw ? 0 : 1) : 0;
        n_flush = rst_n ? m_flush + (e_ief ? 1 : 0) : 0;
    end

    always @(posedge clk) begin
        pend = n_pend;
        waiting = n_waiting;
        m_stall = n_stall;
        m_flush = n_flush;
    end

    // One cycle of stimulus; returns at the following negedge.
    task automatic cyc(input logic r, input logic b, input logic bs, input logic m,
                       input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
        @(posedge clk);
        #1;
        rst_n = r; br = b; busy = bs; mr = m; rd = d; rs1 = s1; rs2 = s2;
        @(negedge clk);
    endtask

    initial begin
        // Reset
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("rst pc_write", pc_write, 0);
        chk("rst if_id_flush", if_id_flush, 1);
        chk("rst id_ex_flush", id_ex_flush, 1);
        chk("rst state", hazard_state, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("idle pc_write", pc_write, 1);
        chk("idle if_id_write", if_id_write, 1);

        // Load-use on rs2, one cycle
        cyc(1, 0, 0, 1, 5, 0, 5);
        chk("lu pc_write", pc_write, 0);
        chk("lu if_id_write", if_id_write, 0);
        chk("lu id_ex_flush", id_ex_flush, 1);
        chk("lu if_id_flush", if_id_flush, 0);
        cyc(1, 0, 0, 0, 5, 0, 5);
        chk("lu after pc_write", pc_write, 1);
        chk("lu after id_ex_flush", id_ex_flush, 0);

        // Destination x0 never stalls
        cyc(1, 0, 0, 1, 0, 0, 0);
        chk("x0 pc_write", pc_write, 1);

        // Persistent load-use on rs1
        cyc(1, 0, 0, 1, 7, 7, 3);
        chk("lu persist 1", pc_write, 0);
        cyc(1, 0, 0, 1, 7, 7, 3);
        chk("lu persist 2", pc_write, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("lu persist end", pc_write, 1);

        // Branch flush window
        cyc(1, 1, 0, 0, 0, 0, 0);
        chk("br0 flushes", {if_id_flush, id_ex_flush}, 2'b11);
        chk("br0 pc_write", pc_write, 1);
        chk("br0 state", hazard_state, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("br1 flushes", {if_id_flush, id_ex_flush}, 2'b11);
        chk("br1 state", hazard_state, 1);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("br2 flushes", {if_id_flush, id_ex_flush}, 2'b00);
        chk("br2 state", hazard_state, 0);

        // Branch interrupted by memory wait
        cyc(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 1, 0, 0, 0, 0);
            chk("mw hold", pipe_hold, 1);
            chk("mw flushes", {if_id_flush, id_ex_flush}, 2'b00);
            chk("mw pc_write", pc_write, 0);
        end
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("mw release hold", pipe_hold, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("mw resumed flush", {if_id_flush, id_ex_flush}, 2'b11);
        chk("mw resumed state", hazard_state, 1);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("mw done flush", id_ex_flush, 0);
        chk("mw done state", hazard_state, 0);

        // Branch wins over load-use; load-use suppressed in FLUSH
        cyc(1, 1, 0, 1, 4, 4, 0);
        chk("br+lu pc_write", pc_write, 1);
        chk("br+lu flushes", {if_id_flush, id_ex_flush}, 2'b11);
        cyc(1, 0, 0, 1, 4, 4, 0);
        chk("flush lu suppressed", pc_write, 1);
        cyc(1, 0, 0, 1, 4, 4, 0);
        chk("lu after flush", pc_write, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);

        // Branch reload during FLUSH
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        chk("reload state", hazard_state, 1);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("reload extra flush", id_ex_flush, 1);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("reload end", id_ex_flush, 0);

        // Reset in the middle of a memory wait
        cyc(1, 0, 1, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 0);
        chk("pre-rst state", hazard_state, 2);
        cyc(0, 0, 1, 0, 0, 0, 0);
        chk("rst-mw hold", pipe_hold, 0);
        chk("rst-mw flush", if_id_flush, 1);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("post-rst state", hazard_state, 0);
        chk("post-rst pc_write", pc_write, 1);
`ifdef HAZARD_PERF_CNT_EN
        chk("post-rst stall_cycles", stall_cycles, 0);
        chk("post-rst flush_cycles", flush_cycles, 0);
`endif

        // Reset in the middle of a flush window
        cyc(1, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("rst-flush abandoned", id_ex_flush, 0);
        chk("rst-flush state", hazard_state, 0);

        // Short mixed tail for the model to track
        cyc(1, 0, 0, 1, 9, 9, 9);
        cyc(1, 0, 1, 1, 9, 9, 9);
        cyc(1, 0, 0, 1, 9, 9, 9);
        cyc(1, 0, 0, 1, 9, 9, 9);
        cyc(1, 0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
